// File: rtl/piso_serializer_ctrl.sv
// Parallel-in/serial-out serializer with valid/ready load, per-beat framing and Done pulse.
// Emits LANES bits per beat, LSB- or MSB-first, with gap-free back-to-back word reloads.
module piso_serializer_ctrl #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned LANES       = 1,
  parameter bit          MSB_FIRST   = 1'b0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic                   Load_Valid,
  output logic                   Load_Ready,
  input  logic [WORD_LENGTH-1:0] Parallel_In,
  output logic [LANES-1:0]       Serial_Out,
  output logic                   Serial_Valid,
  output logic                   Last,
  output logic                   Busy,
  output logic                   Done
);

  localparam int unsigned BEATS = WORD_LENGTH / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if ((WORD_LENGTH % LANES) != 0) begin : gen_bad_lanes
    $error("WORD_LENGTH must be a multiple of LANES");
  end

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   done_q, done_d;

  logic                   at_last;
  logic [WORD_LENGTH-1:0] sreg_shifted;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign at_last = (count_q == LAST_CNT);

  // Shift toward the output end; vacated lanes fill with zeros.
  if (MSB_FIRST) begin : gen_msb
    assign sreg_shifted = sreg_q << LANES;
    assign Serial_Out   = sreg_q[WORD_LENGTH-1 -: LANES];
  end else begin : gen_lsb
    assign sreg_shifted = sreg_q >> LANES;
    assign Serial_Out   = sreg_q[LANES-1:0];
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    done_d  = done_q;

    Load_Ready   = 1'b0;
    Serial_Valid = 1'b0;
    Last         = 1'b0;
    Busy         = 1'b0;

    unique case (state_q)
      StIdle: begin
        Load_Ready = 1'b1;
        if (Enable) begin
          done_d = 1'b0;
          if (Load_Valid) begin
            sreg_d  = Parallel_In;
            count_d = '0;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        Serial_Valid = 1'b1;
        Busy         = 1'b1;
        Last         = at_last;
        Load_Ready   = at_last;
        if (Enable) begin
          done_d = 1'b0;
          if (!at_last) begin
            sreg_d  = sreg_shifted;
            count_d = count_q + CNT_W'(1);
          end else if (Load_Valid) begin
            sreg_d  = Parallel_In;
            count_d = '0;
          end else begin
            sreg_d  = '0;
            count_d = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign Done = done_q;

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Bench for piso_serializer_ctrl: three configurations share stimulus and are checked against a
// word/beat-index reference model, with directed scenarios followed by randomized traffic.
module tb_piso_serializer_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Enable = 1'b0;
  logic       Load_Valid = 1'b0;
  logic [7:0] Parallel_In = '0;

  logic       lr [3];
  logic       sv [3];
  logic       lst[3];
  logic       bsy[3];
  logic       dn [3];
  logic       so0, so1;
  logic [1:0] so2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  piso_serializer_ctrl #(.WORD_LENGTH(8), .LANES(1), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Load_Valid(Load_Valid), .Load_Ready(lr[0]),
    .Parallel_In(Parallel_In), .Serial_Out(so0), .Serial_Valid(sv[0]), .Last(lst[0]),
    .Busy(bsy[0]), .Done(dn[0])
  );

  piso_serializer_ctrl #(.WORD_LENGTH(8), .LANES(1), .MSB_FIRST(1'b1)) u_msb (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Load_Valid(Load_Valid), .Load_Ready(lr[1]),
    .Parallel_In(Parallel_In), .Serial_Out(so1), .Serial_Valid(sv[1]), .Last(lst[1]),
    .Busy(bsy[1]), .Done(dn[1])
  );

  piso_serializer_ctrl #(.WORD_LENGTH(8), .LANES(2), .MSB_FIRST(1'b0)) u_l2 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Load_Valid(Load_Valid), .Load_Ready(lr[2]),
    .Parallel_In(Parallel_In), .Serial_Out(so2), .Serial_Valid(sv[2]), .Last(lst[2]),
    .Busy(bsy[2]), .Done(dn[2])
  );

  // Reference model: current word, index of the beat on the output, active and done flags.
  int unsigned m_word[3];
  int          m_idx [3];
  bit          m_act [3];
  bit          m_done[3];

  function automatic int lanes_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic bit msb_of(input int i);
    return (i == 1);
  endfunction

  function automatic int beats_of(input int i);
    return 8 / lanes_of(i);
  endfunction

  function automatic int unsigned exp_out(input int i);
    int unsigned mask;
    int l;
    l = lanes_of(i);
    mask = (1 << l) - 1;
    if (!m_act[i]) return 0;
    if (msb_of(i)) return (m_word[i] >> (8 - (m_idx[i] + 1) * l)) & mask;
    return (m_word[i] >> (m_idx[i] * l)) & mask;
  endfunction

  function automatic bit exp_last(input int i);
    return m_act[i] && (m_idx[i] == beats_of(i) - 1);
  endfunction

  function automatic bit exp_ready(input int i);
    return !m_act[i] || (m_idx[i] == beats_of(i) - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_word[i] = 0;
      m_idx[i]  = 0;
      m_act[i]  = 1'b0;
      m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit en, input bit lv, input logic [7:0] pin);
    for (int i = 0; i < 3; i++) begin
      if (en) begin
        m_done[i] = 1'b0;
        if (!m_act[i]) begin
          if (lv) begin
            m_word[i] = pin;
            m_idx[i]  = 0;
            m_act[i]  = 1'b1;
          end
        end else if (m_idx[i] < beats_of(i) - 1) begin
          m_idx[i]++;
        end else if (lv) begin
          m_word[i] = pin;
          m_idx[i]  = 0;
        end else begin
          m_act[i]  = 1'b0;
          m_idx[i]  = 0;
          m_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("lsb_out",   32'(so0),    exp_out(0));
    check("msb_out",   32'(so1),    exp_out(1));
    check("l2_out",    32'(so2),    exp_out(2));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("valid%0d", i), 32'(sv[i]),  32'(m_act[i]));
      check($sformatf("busy%0d", i),  32'(bsy[i]), 32'(m_act[i]));
      check($sformatf("last%0d", i),  32'(lst[i]), 32'(exp_last(i)));
      check($sformatf("ready%0d", i), 32'(lr[i]),  32'(exp_ready(i)));
      check($sformatf("done%0d", i),  32'(dn[i]),  32'(m_done[i]));
    end
  endtask

  // Drive inputs, take one edge, update the model and compare 1 time unit later.
  task automatic cycle(input bit en, input bit lv, input logic [7:0] pin);
    Enable      = en;
    Load_Valid  = lv;
    Parallel_In = pin;
    @(posedge Clk);
    model_step(en, lv, pin);
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_out_zero", 32'(so0), 0);
    @(posedge Clk);
    #1;
    check_all();
    #2;
    Reset = 1'b1;
  endtask

  logic [7:0] pat_lsb;
  logic [7:0] pat_msb;
  logic [7:0] pat_l2;

  initial begin
    pat_lsb = 8'hB4;
    pat_msb = 8'h2D;  // 0xB4 bit-reversed, so MSB-first beats read as pat_msb[k]
    pat_l2  = 8'hB4;
    model_reset();
    #1;
    check_all();
    check("reset_ready", 32'(lr[0]), 1);
    #2;
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Single word 0xB4 through all three configurations.
    cycle(1'b1, 1'b1, 8'hB4);
    for (int k = 0; k < 8; k++) begin
      check("b4_lsb_bit", 32'(so0), 32'(pat_lsb[k]));
      check("b4_msb_bit", 32'(so1), 32'(pat_msb[k]));
      if (k < 4) begin
        check("b4_l2_beat", 32'(so2), 32'(pat_l2[2*k +: 2]));
        check("b4_l2_ready", 32'(lr[2]), (k == 3) ? 1 : 0);
      end
      check("b4_lsb_last", 32'(lst[0]), (k == 7) ? 1 : 0);
      cycle(1'b1, 1'b0, 8'h00);
    end
    check("b4_done", 32'(dn[0]), 1);
    cycle(1'b1, 1'b0, 8'h00);
    check("b4_done_clear", 32'(dn[0]), 0);
    check("b4_idle_busy", 32'(bsy[0]), 0);

    // Back-to-back: 0x0F accepted on the last beat of 0xB4.
    cycle(1'b1, 1'b1, 8'hB4);
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h0F);
    check("b2b_no_done", 32'(dn[0]), 0);
    check("b2b_valid", 32'(sv[0]), 1);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 8'h00);
    check("b2b_done", 32'(dn[0]), 1);

    // Enable stall while beat 3 (value 1) is presented.
    cycle(1'b1, 1'b1, 8'hB4);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 8'hFF);
      check("stall_hold", 32'(so0), 1);
    end
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 8'h00);

    // Reset during beat 4, then a fresh word 0x01.
    cycle(1'b1, 1'b1, 8'hB4);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 8'h00);
    pulse_reset();
    cycle(1'b1, 1'b0, 8'h00);
    check("rst_no_done", 32'(dn[0]), 0);
    cycle(1'b1, 1'b1, 8'h01);
    check("post_rst_first", 32'(so0), 1);
    for (int k = 0; k < 9; k++) cycle(1'b1, 1'b0, 8'h00);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        pulse_reset();
      end else begin
        cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
              8'($urandom_range(0, 255)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
